// File: rtl/mem_if_pkg.sv
// +--------------------------------------------------------------------+
// | mem_if_pkg : shared types and constants for the memory request IF   |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_if_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    GAP     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_buffer.sv
// +--------------------------------------------------------------------+
// | mem_cmd_buffer : one-entry command holding register with full flag |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_cmd_buffer
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata
);

  logic              r_full;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Load is only possible while empty and drain only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_write <= i_write;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (i_drain) begin
      r_full  <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_write = r_write;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

`default_nettype wire

// File: rtl/mem_request_master.sv
// +--------------------------------------------------------------------+
// | mem_request_master : CPU-side initiator for memory_control requests |
// | Option: MEM_REQ_TIMEOUT_EN enables the per-transaction wait timeout |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_request_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] request_address,
  output logic              request_type,
  output logic              request,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] memory_in,
  input  logic              memory_ready,
  input  logic              write_complete
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            r_state;
  state_t            w_next;
  logic              r_request;
  logic              r_req_type;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rdata;

  logic              w_buf_full;
  logic              w_buf_write;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_wdata;

  logic w_accept;
  logic w_direct;
  logic w_load;
  logic w_drain;
  logic w_rsp_rd;
  logic w_rsp_wr;
  logic w_timeout;
  logic w_timeout_hit;

  assign cmd_ready = reset & ~w_buf_full;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_direct  = w_accept & (r_state == IDLE) & ~w_buf_full;
  assign w_load    = w_accept & ~w_direct;

  mem_cmd_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_drain (w_drain),
    .i_write (cmd_write),
    .i_addr  (cmd_addr),
    .i_wdata (cmd_wdata),
    .o_full  (w_buf_full),
    .o_write (w_buf_write),
    .o_addr  (w_buf_addr),
    .o_wdata (w_buf_wdata)
  );

  always_comb begin
    w_next    = r_state;
    w_drain   = 1'b0;
    w_rsp_rd  = 1'b0;
    w_rsp_wr  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_buf_full) begin
          w_next  = ISSUE;
          w_drain = 1'b1;
        end else if (w_direct) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        case (r_req_type)
          REQ_READ:  w_next = WAIT_RD;
          REQ_WRITE: w_next = WAIT_WR;
          default:   w_next = WAIT_RD;
        endcase
      end
      WAIT_RD: begin
        if (memory_ready) begin
          w_rsp_rd = 1'b1;
          w_next   = GAP;
        end else if (w_timeout_hit) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      WAIT_WR: begin
        if (write_complete) begin
          w_rsp_wr = 1'b1;
          w_next   = GAP;
        end else if (w_timeout_hit) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      GAP: begin
        if (w_buf_full) begin
          w_next  = ISSUE;
          w_drain = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Pins load on the edge that enters ISSUE so request rises the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_request   <= 1'b0;
      r_req_type  <= REQ_READ;
      r_req_addr  <= '0;
      r_data_out  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_request   <= (w_next == ISSUE) || (w_next == WAIT_RD) || (w_next == WAIT_WR);
      if (w_drain || w_direct) begin
        r_req_type <= w_drain ? w_buf_write : cmd_write;
        r_req_addr <= w_drain ? w_buf_addr  : cmd_addr;
        r_data_out <= w_drain ? w_buf_wdata : cmd_wdata;
      end
      r_rsp_valid <= w_rsp_rd | w_rsp_wr | w_timeout;
      r_rsp_write <= w_rsp_wr;
      if (w_rsp_rd) begin
        r_rdata <= memory_in;
      end
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_err;
  logic             w_waiting;

  assign w_waiting     = (r_state == WAIT_RD) || (r_state == WAIT_WR);
  assign w_timeout_hit = w_waiting && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_rsp_err <= w_timeout;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  // Stores and timeouts report zero data; the last load value is kept underneath.
  assign rsp_rdata       = (r_rsp_valid && (r_rsp_write || rsp_err)) ? '0 : r_rdata;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_write       = r_rsp_write;
  assign busy            = reset & ((r_state != IDLE) | w_buf_full);
  assign request         = r_request;
  assign request_type    = r_req_type;
  assign request_address = r_req_addr;
  assign data_out        = r_data_out;

endmodule

`default_nettype wire

// File: doc/mem_request_master.md
Name: mem_request_master

Overview:
- CPU-side initiator for the memory request interface that memory_control answers.
- Accepts load/store commands from the core's execute stage and holds one command in a 1-deep buffer while another is in flight.
- Drives request_address/request_type/request/data_out, then waits for memory_ready (read) or write_complete (write).
- Returns read data and a completion pulse to the core.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 255, wait limit per transaction; used only with MEM_REQ_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  core presents a command
- cmd_ready  out  1  block can accept a command this cycle
- cmd_write  in  1  1=store, 0=load
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  completed transaction was a store
- rsp_rdata  out  DATA_W  load data; 0 for stores
- rsp_err  out  1  transaction timed out
- busy  out  1  transaction in flight or buffered
- request_address  out  ADDR_W  to memory
- request_type  out  1  1=write, 0=read
- request  out  1  request strobe
- data_out  out  DATA_W  write data to memory
- memory_in  in  DATA_W  read data from memory
- memory_ready  in  1  read data valid
- write_complete  in  1  write accepted

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low.
  - While reset==0, all outputs are 0 and the buffer is empty.
  - FSM goes to IDLE; cmd_ready=0 during reset.
  - Asserting reset mid-transaction drops request the next edge and loses the buffered command. There is no rsp_valid for either.
- Accept:
  - A command is accepted on a clock edge where cmd_valid && cmd_ready.
  - cmd_ready = ~buf_full.
  - An accepted command goes to the buffer, except in IDLE with the buffer empty, where it goes directly to issue.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP.
  - IDLE -> ISSUE when a command is available (buffer or direct).
  - ISSUE: latch address/type/data onto memory pins and set request=1. Go to WAIT_RD or WAIT_WR the next cycle. request rises 1 cycle after acceptance.
  - WAIT_RD: hold request=1 and all request pins stable.
    - On memory_ready==1, capture memory_in into rsp_rdata.
    - Pulse rsp_valid=1 with rsp_write=0 on the following cycle.
    - Drop request, go to GAP.
  - WAIT_WR: on write_complete==1, pulse rsp_valid with rsp_write=1 and rsp_rdata=0. Drop request, go to GAP.
  - GAP: request=0 for exactly one cycle (mandatory idle between requests). Then ISSUE if the buffer is full, else IDLE.
- Response signals:
  - Ignore memory_ready in WAIT_WR and write_complete in WAIT_RD.
  - Ignore both responses in IDLE, ISSUE and GAP.
  - rsp_valid has no back-pressure; the core must consume it.
  - rsp_rdata holds its value until the next read completes.
- Buffer:
  - A command accepted in the same cycle the buffer drains (GAP->ISSUE) is legal.
  - cmd_ready stays 0 that cycle because the buffer is still full until the edge; no bypass.
- busy = (state != IDLE) || buf_full.
- Latency: best-case read acceptance -> rsp_valid = 3 cycles with memory_ready asserted on the first wait cycle.

Optional Feature:
- MEM_REQ_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in WAIT_RD/WAIT_WR.
  - When it reaches TIMEOUT_CYCLES without a response, drop request and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - Go to GAP.
  - The counter clears in ISSUE.
- Not defined: wait indefinitely; rsp_err tied 0; no counter logic.

Decomposition:
- Package mem_if_pkg:
  - state enum (IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP)
  - REQ_READ=1'b0, REQ_WRITE=1'b1
  - default ADDR_W/DATA_W
- One natural sub-module: mem_cmd_buffer, the 1-entry command holding register with full flag, load/drain.

Test Plan:
- Read: cmd load addr 16'h0040, memory_ready high 2 cycles after request rises with memory_in=16'hBEEF -> request_type=0, address stable throughout, rsp_valid 1 cycle, rsp_rdata=16'hBEEF, request low for 1 GAP cycle.
- Write: cmd store addr 16'h1234 data 16'hA5A5, write_complete after 4 cycles -> data_out=16'hA5A5 held, rsp_valid with rsp_write=1, rsp_rdata=0.
- Back-to-back: store 16'h0001 then load 16'h0002 on consecutive cycles -> second accepted into buffer, cmd_ready=0 until drain, second request rises exactly 1 cycle after first drops.
- Wrong response: memory_ready pulsed during WAIT_WR -> ignored, no rsp_valid until write_complete.
- Reset mid-WAIT_RD: reset=0 for 1 cycle -> request=0, busy=0, no rsp_valid, next command issues normally.
- Timeout (MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): read with no memory_ready -> rsp_valid with rsp_err=1 after 8 wait cycles, request drops.
